hrange_accum: RTL and testbench

- Downstream consumer stage for a tuple generator that uses the ready/valid protocol (base/limit/step in, (_0,_1) pairs out).
- On _start, it launches the upstream generator with the captured arguments. It pulls every yielded pair, accumulates a running total of _0+_1 and a count, and re-yields (total, count) downstream under the same ready/valid/done protocol.
- Python equivalent: `total=0; count=0; for a,b in hrange(base,limit,step): total+=a+b; count+=1; yield total, count`.
- The generator is a sibling instance wired by the parent; it is not instantiated inside this block.

---
 rtl/hrange_pkg.sv | 11 +
 rtl/hrange_accum.sv | 118 +++++++++++
 tb/tb_hrange_accum.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hrange_pkg.sv
// Shared constants for the hrange consumer stage: FSM state encoding and default data width.
package hrange_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [1:0] S_DONE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_PULL   = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

endpackage

// File: rtl/hrange_accum.sv
// Consumer of the hrange generator: sums each yielded pair into a running total and
// re-yields (total, count) downstream under the same ready/valid/done protocol.
module hrange_accum
  import hrange_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             _clock,
  input  logic             _reset_n,
  input  logic             _start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] step,
  input  logic             _ready,
  output logic             _valid,
  output logic             _done,
  output logic [WIDTH-1:0] _0,
  output logic [WIDTH-1:0] _1,
  output logic             _inner_start,
  output logic [WIDTH-1:0] _inner_base,
  output logic [WIDTH-1:0] _inner_limit,
  output logic [WIDTH-1:0] _inner_step,
  output logic             _inner_ready,
  input  logic             _inner_valid,
  input  logic             _inner_done,
  input  logic [WIDTH-1:0] _inner_0,
  input  logic [WIDTH-1:0] _inner_1
);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             r_valid;
  logic             r_done;
  logic             r_inner_start;
  logic [WIDTH-1:0] r_total;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_limit;
  logic [WIDTH-1:0] r_step;
  logic             w_inner_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_sum;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values and process ordering in simulation cannot change the result.
  always_ff @(posedge _clock) begin
    if (!_reset_n) r_state <= S_DONE;
    else           r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    if (_start) begin
      w_next_state = S_LAUNCH;
    end else begin
      case (r_state)
        S_LAUNCH: w_next_state = S_PULL;
        S_PULL:   if (_inner_done) w_next_state = S_DRAIN;
        S_DRAIN:  if (!r_valid || _ready) w_next_state = S_DONE;
        default:  w_next_state = r_state;
      endcase
    end
  end

  // A restart refuses any pair on offer so the aborted run cannot leak into the new one.
  always_comb begin
    w_inner_ready = 1'b0;
    if (!_start && (r_state == S_PULL)) w_inner_ready = !r_valid || _ready;
  end

  assign w_accept = w_inner_ready && _inner_valid;
  // Two's-complement wrap makes unsigned and signed addition bit-identical here.
  assign w_sum    = r_total + _inner_0 + _inner_1;

  always_ff @(posedge _clock) begin
    if (!_reset_n) begin
      r_valid       <= 1'b0;
      r_done        <= 1'b0;
      r_inner_start <= 1'b0;
      r_total       <= '0;
      r_count       <= '0;
      r_base        <= '0;
      r_limit       <= '0;
      r_step        <= '0;
    end else begin
      r_inner_start <= 1'b0;
      r_done        <= (w_next_state == S_DONE);
      if (_start) begin
        r_base        <= base;
        r_limit       <= limit;
        r_step        <= step;
        r_total       <= '0;
        r_count       <= '0;
        r_valid       <= 1'b0;
        r_inner_start <= 1'b1;
      end else if (w_accept) begin
        r_total <= w_sum;
        r_count <= r_count + WIDTH'(1);
        r_valid <= 1'b1;
      end else if (_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  // The accumulators double as the output registers, so a new run starts from (0, 0).
  assign _valid       = r_valid;
  assign _done        = r_done;
  assign _0           = r_total;
  assign _1           = r_count;
  assign _inner_start = r_inner_start;
  assign _inner_base  = r_base;
  assign _inner_limit = r_limit;
  assign _inner_step  = r_step;
  assign _inner_ready = w_inner_ready;

endmodule

// File: tb/tb_hrange_accum.sv
// Self-checking bench for hrange_accum: a behavioural hrange generator drives the inner
// port, and a Python-level model of the accumulate loop predicts every downstream yield.
`timescale 1ns/1ps
module tb_hrange_accum;
  import hrange_pkg::*;

  localparam int W = 32;

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; } pair_t;
  typedef struct { logic [W-1:0] t; logic [W-1:0] c; } out_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         rdy = 1'b0;
  logic [W-1:0] base = '0, limit = '0, step = '0;
  logic         valid, done, inner_start, inner_ready;
  logic [W-1:0] out0, out1, ib, il, is;
  logic         g_valid = 1'b0, g_done = 1'b0;
  logic [W-1:0] g_0 = '0, g_1 = '0;

  hrange_accum #(.WIDTH(W)) dut (
    ._clock(clk), ._reset_n(rst_n), ._start(start),
    .base(base), .limit(limit), .step(step), ._ready(rdy),
    ._valid(valid), ._done(done), ._0(out0), ._1(out1),
    ._inner_start(inner_start), ._inner_base(ib), ._inner_limit(il), ._inner_step(is),
    ._inner_ready(inner_ready), ._inner_valid(g_valid), ._inner_done(g_done),
    ._inner_0(g_0), ._inner_1(g_1)
  );

  always #5 clk = ~clk;

  int    n_pass = 0;
  int    n_total = 0;
  int    ready_mode = 0;     // 0: always ready, 1: random, 2: held low
  bit    use_stub = 1'b0;
  pair_t stub_q[$];
  out_t  exp_q[$];
  out_t  got_q[$];

  // generator state
  pair_t g_q[$];
  bit    g_active = 1'b0, g_done_sent = 1'b0, g_level = 1'b0, g_hs = 1'b0;

  // previous-cycle samples for the output-stability check
  logic         p_valid = 1'b0, p_ready = 1'b0, p_start = 1'b0, p_rst = 1'b0;
  logic [W-1:0] p0 = '0, p1 = '0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Python range() membership
  function automatic bit in_range(input logic [W-1:0] v, input logic [W-1:0] l,
                                  input logic [W-1:0] s);
    if (s == '0) return 1'b0;
    if ($signed(s) > 0) return $signed(v) < $signed(l);
    return $signed(v) > $signed(l);
  endfunction

  task automatic gen_step();
    logic [W-1:0] v;
    if (!rst_n) begin
      g_active = 1'b0; g_valid = 1'b0; g_done = 1'b0; g_q.delete();
    end else if (inner_start) begin
      g_q.delete();
      if (use_stub) begin
        foreach (stub_q[k]) g_q.push_back(stub_q[k]);
      end else begin
        v = ib;
        while (in_range(v, il, is)) begin
          g_q.push_back('{a: v, b: v});
          v = v + is;
        end
      end
      g_active = 1'b1; g_valid = 1'b0; g_done = 1'b0; g_done_sent = 1'b0;
      g_level = 1'($urandom_range(0, 1));
    end else if (g_active) begin
      if (g_hs) void'(g_q.pop_front());
      if (g_q.size() == 0) begin
        g_valid = 1'b0;
        if (!g_done_sent) begin g_done = 1'b1; g_done_sent = 1'b1; end
        else g_done = g_level;
      end else begin
        if (!(g_valid && !g_hs)) g_valid = ($urandom_range(0, 2) != 0);
        g_0 = g_q[0].a;
        g_1 = g_q[0].b;
        g_done = 1'b0;
        if (g_valid && g_q.size() == 1 && inner_ready && ($urandom_range(0, 1) == 1)) begin
          g_done = 1'b1; g_done_sent = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_cycle();
    out_t e;
    if (p_rst && !p_start && p_valid && !p_ready) begin
      check("hold_valid", valid, 1'b1);
      check("hold_total", out0, p0);
      check("hold_count", out1, p1);
    end
    if (rst_n) begin
      if (valid && !rdy && !start) check("bp_inner_ready", inner_ready, 1'b0);
      if (done) check("done_excludes_valid", valid, 1'b0);
      if (valid && rdy) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got (0x%08h,0x%08h), expected none", out0, out1);
        end else begin
          e = exp_q.pop_front();
          check("out_total", out0, e.t);
          check("out_count", out1, e.c);
        end
        got_q.push_back('{t: out0, c: out1});
      end
    end
    p_valid = valid; p_ready = rdy; p_start = start; p_rst = rst_n; p0 = out0; p1 = out1;
  endtask

  // one clock cycle: entered and left at posedge+1
  task automatic tick();
    case (ready_mode)
      0:       rdy = 1'b1;
      2:       rdy = 1'b0;
      default: rdy = ($urandom_range(0, 3) != 0);
    endcase
    #1 gen_step();
    #1 g_hs = g_valid && inner_ready;
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [W-1:0] b, input logic [W-1:0] l, input logic [W-1:0] s);
    logic [W-1:0] v, tot, cnt;
    start = 1'b1; base = b; limit = l; step = s;
    tick();
    start = 1'b0; base = $urandom; limit = $urandom; step = $urandom;
    exp_q.delete(); got_q.delete();
    tot = '0; cnt = '0;
    if (use_stub) begin
      foreach (stub_q[k]) begin
        tot = tot + stub_q[k].a + stub_q[k].b; cnt = cnt + 1;
        exp_q.push_back('{t: tot, c: cnt});
      end
    end else begin
      for (v = b; in_range(v, l, s); v = v + s) begin
        tot = tot + v + v; cnt = cnt + 1;
        exp_q.push_back('{t: tot, c: cnt});
      end
    end
    check("launch_inner_start", inner_start, 1'b1);
    check("launch_inner_base", ib, b);
    check("launch_inner_limit", il, l);
    check("launch_inner_step", is, s);
    check("launch_done_low", done, 1'b0);
    tick();
    check("inner_start_one_cycle", inner_start, 1'b0);
  endtask

  task automatic wait_done(input int budget, input string name);
    int i;
    for (i = 0; i < budget && !done; i++) tick();
    if (!done) fail_now(name);
    else begin
      check("drained_all", exp_q.size(), 0);
      check("idle_valid_low", valid, 1'b0);
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int i;
    for (i = 0; i < budget && !valid; i++) tick();
    if (!valid) fail_now(name);
  endtask

  task automatic check_got(input string name, input int n, input int lt[5], input int lc[5]);
    check({name, "_len"}, got_q.size(), n);
    for (int k = 0; k < n && k < got_q.size(); k++) begin
      check({name, "_total"}, got_q[k].t, lt[k]);
      check({name, "_count"}, got_q[k].c, lc[k]);
    end
  endtask

  initial begin : main
    int lt[5], lc[5];
    logic [W-1:0] rb, rl, rs;
    @(posedge clk); #1;
    rst_n = 1'b0;
    tick(); tick();
    check("rst_valid", valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_total", out0, '0);
    check("rst_count", out1, '0);
    check("rst_inner_start", inner_start, 1'b0);
    check("rst_inner_ready", inner_ready, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_done", done, 1'b1);

    // normal run
    ready_mode = 0;
    start_run(0, 10, 2);
    wait_done(80, "normal_done");
    lt = '{0, 4, 12, 24, 40}; lc = '{1, 2, 3, 4, 5};
    check_got("normal", 5, lt, lc);
    repeat (3) begin tick(); check("after_done_valid", valid, 1'b0); check("after_done", done, 1'b1); end

    // empty range
    start_run(5, 5, 1);
    wait_done(3, "empty_done");
    check("empty_total", out0, '0);
    check("empty_count", out1, '0);
    check("empty_no_yield", got_q.size(), 0);

    // backpressure on the first output
    ready_mode = 2;
    start_run(0, 10, 2);
    wait_valid(30, "bp_first_valid");
    repeat (3) begin
      check("bp_total", out0, 0);
      check("bp_count", out1, 1);
      check("bp_ready_low", inner_ready, 1'b0);
      tick();
    end
    ready_mode = 0;
    wait_done(80, "bp_done");
    check_got("bp", 5, lt, lc);

    // overflow via stub pairs
    use_stub = 1'b1;
    stub_q.delete();
    stub_q.push_back('{a: 32'h4000_0000, b: 32'h4000_0000});
    stub_q.push_back('{a: 32'h8000_0000, b: 32'h7fff_ffff});
    ready_mode = 2;
    start_run(0, 0, 0);
    wait_valid(30, "ovf_valid");
    check("ovf_total", out0, 32'h8000_0000);
    check("ovf_count", out1, 1);
    ready_mode = 0;
    wait_done(40, "ovf_done");
    check("ovf_wrap_total", got_q.size() == 2 ? got_q[1].t : 32'hx, 32'h7fff_ffff);
    use_stub = 1'b0;

    // restart after (12,3)
    start_run(0, 10, 2);
    begin
      int i;
      for (i = 0; i < 60 && got_q.size() < 3; i++) tick();
      if (got_q.size() < 3) fail_now("restart_third_output");
    end
    start_run(1, 4, 1);
    wait_done(60, "restart_done");
    lt = '{2, 6, 12, 0, 0}; lc = '{1, 2, 3, 0, 0};
    check_got("restart", 3, lt, lc);

    // reset in the middle of a run
    ready_mode = 1;
    start_run(0, 10, 2);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("mrst_valid", valid, 1'b0);
    check("mrst_total", out0, '0);
    check("mrst_count", out1, '0);
    check("mrst_inner_start", inner_start, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_inner_base", ib, '0);
    exp_q.delete();
    rst_n = 1'b1;
    tick();
    repeat (5) begin check("mrst_idle_done", done, 1'b1); check("mrst_idle_valid", valid, 1'b0); tick(); end

    // randomized runs, some aborted by a restart
    for (int r = 0; r < 30; r++) begin
      rb = W'($urandom_range(0, 40)) - W'(20);
      rl = W'($urandom_range(0, 40)) - W'(20);
      rs = W'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) rs = -rs;
      if ($urandom_range(0, 9) == 0) rs = '0;
      start_run(rb, rl, rs);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(2, 10)) tick();
      else wait_done(400, "rand_done");
    end
    wait_done(400, "final_done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
